pcs_rx_block_sync: RTL and testbench



---
 rtl/pcs_pkg.sv | 35 +++
 rtl/pcs_rx_block_sync.sv | 151 +++++++++++++++
 tb/tb_pcs_rx_block_sync.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pcs_pkg.sv
// -----------------------------------------------------------------------------
// pcs_pkg
// Constants and types shared by the 40G PCS receive path and its benches.
//   HEAD_W / DATA_W       : 66b block split into sync header and payload
//   SYNC_DATA / SYNC_CTRL : the two legal sync header values
//   SH_CNT_MAX            : headers tested per block-lock window
//   SH_INV_MAX            : invalid headers in a window that drop lock
//   SLIP_WAIT             : cycles the gearbox needs to settle after a slip
//   bls_state_t           : block-lock state machine encoding
// -----------------------------------------------------------------------------
package pcs_pkg;

  localparam int HEAD_W     = 2;
  localparam int DATA_W     = 64;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int SH_CNT_MAX = 64;
  localparam int SH_INV_MAX = 16;
  localparam int SLIP_WAIT  = 3;

  typedef enum logic [1:0] {
    RESET_CNT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP      = 2'd2,
    WAIT      = 2'd3
  } bls_state_t;

  // A sync header is legal only when its two bits differ (01 or 10).
  function automatic logic sh_is_valid(input logic [1:0] head);
    return head[0] ^ head[1];
  endfunction

endpackage

// File: rtl/pcs_rx_block_sync.sv
// -----------------------------------------------------------------------------
// pcs_rx_block_sync
// Per-lane 66b block lock for the 40G PCS receive path. Sits right after the
// RX gearbox, tests the sync header of every block and runs the block-lock
// state machine. While unlocked any bad header makes the gearbox slip one bit;
// once locked the blocks are forwarded with lock_o as the qualifier.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous reset, active-high
//   valid_i  in   gearbox holds a complete 66b block this cycle
//   head_i   in   sync header [HEAD_W]
//   data_i   in   block payload [DATA_W]
//   slip_o   out  one-cycle pulse: shift block boundary by one bit
//   lock_o   out  block lock achieved
//   valid_o  out  registered valid_i
//   head_o   out  registered head_i [HEAD_W]
//   data_o   out  registered data_i [DATA_W]
// -----------------------------------------------------------------------------
module pcs_rx_block_sync #(
  parameter int DATA_W     = pcs_pkg::DATA_W,
  parameter int HEAD_W     = pcs_pkg::HEAD_W,
  parameter int SH_CNT_MAX = pcs_pkg::SH_CNT_MAX,
  parameter int SH_INV_MAX = pcs_pkg::SH_INV_MAX,
  parameter int SLIP_WAIT  = pcs_pkg::SLIP_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              slip_o,
  output logic              lock_o,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o
);
  import pcs_pkg::*;

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INV_MAX + 1);
  // +2 keeps the counter at least one bit wide even for SLIP_WAIT == 0.
  localparam int WAIT_W = $clog2(SLIP_WAIT + 2);

  bls_state_t        r_state;
  logic [CNT_W-1:0]  r_sh_cnt;
  logic [INV_W-1:0]  r_sh_inv_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_slip;
  logic              r_lock;
  logic              r_valid;
  logic [HEAD_W-1:0] r_head;
  logic [DATA_W-1:0] r_data;

  logic              w_sh_bad;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [INV_W-1:0]  w_inv_inc;
  logic              w_cnt_full;
  logic              w_inv_full;

  assign w_sh_bad   = !sh_is_valid(head_i[1:0]);
  assign w_cnt_inc  = r_sh_cnt + CNT_W'(1);
  assign w_inv_inc  = r_sh_inv_cnt + INV_W'(w_sh_bad);
  // Counters never wrap: reaching either limit always leaves TEST_SH, and
  // only RESET_CNT clears them.
  assign w_cnt_full = (w_cnt_inc == CNT_W'(SH_CNT_MAX));
  assign w_inv_full = (w_inv_inc == INV_W'(SH_INV_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RESET_CNT;
      r_sh_cnt     <= '0;
      r_sh_inv_cnt <= '0;
      r_wait_cnt   <= '0;
      r_slip       <= 1'b0;
      r_lock       <= 1'b0;
      r_valid      <= 1'b0;
      r_head       <= '0;
      r_data       <= '0;
    end else begin
      // Datapath is a plain pipeline stage; downstream qualifies with lock_o.
      r_valid <= valid_i;
      r_head  <= head_i;
      r_data  <= data_i;

      // slip_o is high exactly while the FSM sits in SLIP: it is set on the
      // edge that enters SLIP and cleared by default on the next one.
      r_slip  <= 1'b0;

      case (r_state)
        RESET_CNT: begin
          r_sh_cnt     <= '0;
          r_sh_inv_cnt <= '0;
          r_state      <= TEST_SH;
        end

        TEST_SH: begin
          if (valid_i) begin
            r_sh_cnt     <= w_cnt_inc;
            r_sh_inv_cnt <= w_inv_inc;
            if (!r_lock) begin
              // Unlocked: a single bad header means the boundary is wrong.
              if (w_sh_bad) begin
                r_slip  <= 1'b1;
                r_state <= SLIP;
              end else if (w_cnt_full) begin
                r_lock  <= 1'b1;
                r_state <= RESET_CNT;
              end
            end else begin
              // Locked: losing lock takes priority over closing the window,
              // so a 64th header that is also the 16th bad one still slips.
              if (w_inv_full) begin
                r_lock  <= 1'b0;
                r_slip  <= 1'b1;
                r_state <= SLIP;
              end else if (w_cnt_full) begin
                r_state <= RESET_CNT;
              end
            end
          end
        end

        SLIP: begin
          r_wait_cnt <= WAIT_W'(SLIP_WAIT);
          r_state    <= WAIT;
        end

        WAIT: begin
          // Input is ignored here while the gearbox settles on its new
          // boundary; stays SLIP_WAIT cycles (at least one).
          if (r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
          end
          if (r_wait_cnt <= WAIT_W'(1)) begin
            r_state <= RESET_CNT;
          end
        end

        default: r_state <= RESET_CNT;
      endcase
    end
  end

  assign slip_o  = r_slip;
  assign lock_o  = r_lock;
  assign valid_o = r_valid;
  assign head_o  = r_head;
  assign data_o  = r_data;

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// -----------------------------------------------------------------------------
// tb_pcs_rx_block_sync
// Directed bench for the per-lane block-lock stage. Inputs change 1 ns after
// the rising edge and outputs are checked at the same point, so each check
// sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_pcs_rx_block_sync;
  import pcs_pkg::*;

  logic              clk;
  logic              reset;
  logic              valid_i;
  logic [HEAD_W-1:0] head_i;
  logic [DATA_W-1:0] data_i;
  logic              slip_o;
  logic              lock_o;
  logic              valid_o;
  logic [HEAD_W-1:0] head_o;
  logic [DATA_W-1:0] data_o;

  int checks = 0;
  int errors = 0;
  int slip_pulses = 0;
  int slip_while_locked = 0;
  int slip_base = 0;
  logic [DATA_W-1:0] last_data;

  pcs_rx_block_sync dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .head_i  (head_i),
    .data_i  (data_i),
    .slip_o  (slip_o),
    .lock_o  (lock_o),
    .valid_o (valid_o),
    .head_o  (head_o),
    .data_o  (data_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mid-cycle monitor: counts slip pulses and any slip seen while locked.
  always @(negedge clk) begin
    if (!reset && slip_o) slip_pulses = slip_pulses + 1;
    if (slip_o && lock_o) slip_while_locked = slip_while_locked + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: present a block, take the edge, settle 1 ns.
  task automatic cyc(input logic v, input logic [1:0] h);
    valid_i   = v;
    head_i    = h;
    data_i    = {$urandom, $urandom};
    last_data = data_i;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] good_hdr(input int i);
    return (i % 2 == 1) ? SYNC_CTRL : SYNC_DATA;
  endfunction

  initial begin
    reset   = 1'b1;
    valid_i = 1'b0;
    head_i  = '0;
    data_i  = '0;

    // ---- reset state ----
    cyc(1'b1, SYNC_DATA);
    cyc(1'b1, SYNC_DATA);
    check("rst_lock",  64'(lock_o),  64'd0);
    check("rst_slip",  64'(slip_o),  64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_head",  64'(head_o),  64'd0);
    check("rst_data",  data_o,       64'd0);
    $display("step reset: lock=%0d slip=%0d valid_o=%0d", lock_o, slip_o, valid_o);

    reset = 1'b0;
    cyc(1'b0, 2'b00);                         // RESET_CNT cycle

    // ---- misaligned start: bad header at block 5 ----
    slip_base = slip_pulses;
    for (int i = 0; i < 4; i++) cyc(1'b1, good_hdr(i));
    check("dp_valid", 64'(valid_o), 64'd1);
    check("dp_head",  64'(head_o),  64'(SYNC_CTRL));
    check("dp_data",  data_o,       last_data);
    cyc(1'b1, 2'b00);
    check("mis_slip_hi", 64'(slip_o), 64'd1);
    check("mis_lock",    64'(lock_o), 64'd0);
    $display("step misaligned: slip=%0d lock=%0d", slip_o, lock_o);
    cyc(1'b1, 2'b00);                         // SLIP state
    check("mis_slip_lo", 64'(slip_o), 64'd0);
    check("dp_data_slip", data_o, last_data);
    repeat (4) cyc(1'b1, 2'b00);              // WAIT x3 + RESET_CNT: ignored
    check("mis_one_slip", 64'(slip_pulses - slip_base), 64'd1);
    for (int i = 0; i < 63; i++) cyc(1'b1, good_hdr(i));
    check("relock_63", 64'(lock_o), 64'd0);
    cyc(1'b1, SYNC_DATA);
    check("relock_64", 64'(lock_o), 64'd1);
    check("relock_noslip", 64'(slip_pulses - slip_base), 64'd1);
    $display("step relock: lock=%0d slips=%0d", lock_o, slip_pulses - slip_base);

    // ---- locked, 15 invalid in a window: lock held ----
    slip_base = slip_pulses;
    cyc(1'b0, 2'b00);                         // RESET_CNT
    for (int i = 0; i < 64; i++) cyc(1'b1, (i < 15) ? 2'b11 : good_hdr(i));
    check("inv15_lock", 64'(lock_o), 64'd1);
    check("inv15_slip", 64'(slip_pulses - slip_base), 64'd0);
    $display("step inv15: lock=%0d", lock_o);

    // ---- locked, 16th invalid at block 40 ----
    cyc(1'b0, 2'b00);                         // RESET_CNT
    for (int i = 0; i < 39; i++) cyc(1'b1, (i < 24) ? good_hdr(i) : 2'b11);
    check("inv16_pre_lock", 64'(lock_o), 64'd1);
    cyc(1'b1, 2'b11);
    check("inv16_lock", 64'(lock_o), 64'd0);
    check("inv16_slip", 64'(slip_o), 64'd1);
    cyc(1'b0, 2'b00);                         // SLIP state
    check("inv16_slip_lo", 64'(slip_o), 64'd0);
    $display("step inv16: lock=%0d slip=%0d", lock_o, slip_o);

    // ---- valid_i gaps: counters hold ----
    repeat (4) cyc(1'b0, 2'b00);              // WAIT x3 + RESET_CNT
    for (int i = 0; i < 63; i++) begin
      cyc(1'b1, good_hdr(i));
      if (i % 8 == 7) cyc(1'b0, 2'b11);       // gap with an illegal header
    end
    check("gap_63", 64'(lock_o), 64'd0);
    cyc(1'b0, 2'b11);
    check("gap_hold", 64'(lock_o), 64'd0);
    check("gap_valid_o", 64'(valid_o), 64'd0);
    cyc(1'b1, SYNC_CTRL);
    check("gap_lock", 64'(lock_o), 64'd1);
    $display("step gaps: lock=%0d", lock_o);

    // ---- 64th header is the 16th invalid: lose lock wins ----
    cyc(1'b0, 2'b00);                         // RESET_CNT
    for (int i = 0; i < 48; i++) cyc(1'b1, good_hdr(i));
    for (int i = 0; i < 15; i++) cyc(1'b1, 2'b11);
    check("prio_pre_lock", 64'(lock_o), 64'd1);
    cyc(1'b1, 2'b00);
    check("prio_lock", 64'(lock_o), 64'd0);
    check("prio_slip", 64'(slip_o), 64'd1);
    $display("step priority: lock=%0d slip=%0d", lock_o, slip_o);
    cyc(1'b0, 2'b00);                         // SLIP state
    repeat (4) cyc(1'b0, 2'b00);              // WAIT x3 + RESET_CNT

    // ---- unlocked, 64th header invalid: slip, no lock ----
    for (int i = 0; i < 63; i++) cyc(1'b1, good_hdr(i));
    cyc(1'b1, 2'b11);
    check("unl64_slip", 64'(slip_o), 64'd1);
    check("unl64_lock", 64'(lock_o), 64'd0);
    cyc(1'b0, 2'b00);                         // SLIP state, next is WAIT
    $display("step unlocked64: lock=%0d", lock_o);

    // ---- reset during WAIT ----
    reset = 1'b1;
    cyc(1'b1, SYNC_DATA);
    check("wrst_lock",  64'(lock_o),  64'd0);
    check("wrst_slip",  64'(slip_o),  64'd0);
    check("wrst_valid", 64'(valid_o), 64'd0);
    check("wrst_data",  data_o,       64'd0);
    reset = 1'b0;
    cyc(1'b1, 2'b00);                         // RESET_CNT ignores this header
    check("wrst_resetcnt", 64'(slip_o), 64'd0);
    for (int i = 0; i < 63; i++) cyc(1'b1, good_hdr(i));
    check("wrst_63", 64'(lock_o), 64'd0);
    cyc(1'b1, SYNC_DATA);
    check("wrst_lock64", 64'(lock_o), 64'd1);
    $display("step reset_in_wait: lock=%0d", lock_o);

    check("slip_never_locked", 64'(slip_while_locked), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
